// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - bundle of the EX-side and data-memory-side signals of mem_stage
//
// Purpose : groups every handshake/bus signal of mem_stage so the stage and
//           its environment connect through one port.
// Modports: master - environment side (drives EX inputs, memory read data/ack)
//           slave  - mem_stage side (drives stall, memory request, writeback)
// Signals : in_valid/ins/result/rdata2 - EX result in, held while stall
//           stall                      - upstream must hold while high
//           dm_req/dm_we/dm_addr/dm_be/dm_wdata - data memory request
//           dm_rdata/dm_ack            - data memory response
//           out_valid/wdata/misalign/err - one-cycle writeback result

interface mem_stage_if;
    logic        in_valid;
    logic [31:0] ins;
    logic [31:0] result;
    logic [31:0] rdata2;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        out_valid;
    logic [31:0] wdata;
    logic        misalign;
    logic        err;

    modport master (
        output in_valid, ins, result, rdata2, dm_rdata, dm_ack,
        input  stall, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  out_valid, wdata, misalign, err
    );

    modport slave (
        input  in_valid, ins, result, rdata2, dm_rdata, dm_ack,
        output stall, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output out_valid, wdata, misalign, err
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: loads/stores to data memory with timeout
//
// Purpose : pass-through for non-memory instructions, alignment check, data
//           memory access with lane steering, load extraction and a wait
//           timeout that reports err instead of hanging the pipeline.
// Params  : TIMEOUT - ACCESS cycles allowed without dm_ack (1..255)
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - mem_stage_if.slave (EX inputs, memory bus, writeback)

module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_stage_if.slave   bus
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Timeout fires on the edge that would make the count reach TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [5:0]  cap_op;
    logic [31:0] cap_result;

    logic [5:0]  op;
    logic        is_mem;
    logic        is_store;
    logic        misal;
    logic [3:0]  be_c;
    logic [31:0] bwd_c;
    logic [15:0] lane;
    logic [31:0] load_data;
    logic        unused_ins;

    assign op         = bus.ins[31:26];
    assign unused_ins = ^bus.ins[25:0];
    assign bus.stall  = (state != IDLE);

    // Decode of the instruction presented by EX.
    always_comb begin
        is_mem = 1'b1;
        misal  = 1'b0;
        be_c   = 4'b0000;
        bwd_c  = 32'h0;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                be_c  = 4'b0001 << bus.result[1:0];
                bwd_c = {4{bus.rdata2[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misal = bus.result[0];
                be_c  = bus.result[1] ? 4'b1100 : 4'b0011;
                bwd_c = {2{bus.rdata2[15:0]}};
            end
            OP_LW, OP_SW: begin
                misal = |bus.result[1:0];
                be_c  = 4'b1111;
                bwd_c = bus.rdata2;
            end
            default: is_mem = 1'b0;
        endcase
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    end

    // Bring the addressed lane down to bit 0, then extend by load type.
    always_comb begin
        lane = 16'(bus.dm_rdata >> {cap_result[1:0], 3'b000});
        case (cap_op)
            OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  load_data = {24'h0, lane[7:0]};
            OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  load_data = {16'h0, lane[15:0]};
            default: load_data = bus.dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= 8'h0;
            cap_op        <= 6'h0;
            cap_result    <= 32'h0;
            bus.dm_req    <= 1'b0;
            bus.dm_we     <= 1'b0;
            bus.dm_addr   <= 32'h0;
            bus.dm_be     <= 4'h0;
            bus.dm_wdata  <= 32'h0;
            bus.out_valid <= 1'b0;
            bus.wdata     <= 32'h0;
            bus.misalign  <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.misalign  <= 1'b0;
            bus.err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!is_mem) begin
                            bus.out_valid <= 1'b1;
                            bus.wdata     <= bus.result;
                        end else if (misal) begin
                            bus.out_valid <= 1'b1;
                            bus.misalign  <= 1'b1;
                            bus.wdata     <= 32'h0;
                        end else begin
                            state        <= ACCESS;
                            wait_cnt     <= 8'h0;
                            cap_op       <= op;
                            cap_result   <= bus.result;
                            bus.dm_req   <= 1'b1;
                            bus.dm_we    <= is_store;
                            bus.dm_addr  <= {bus.result[31:2], 2'b00};
                            bus.dm_be    <= be_c;
                            bus.dm_wdata <= bwd_c;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (bus.dm_ack) begin
                        state         <= RESP;
                        bus.dm_req    <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.wdata     <= bus.dm_we ? cap_result : load_data;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                        if (wait_cnt == WAIT_LAST) begin
                            state         <= RESP;
                            bus.dm_req    <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.err       <= 1'b1;
                            bus.wdata     <= 32'h0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a behavioural model

module tb_mem_stage;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Observations of one transaction
    int          o_ov_it, o_ov_cnt, o_mis_cnt, o_err_cnt, o_req_cycles, o_stall_cnt, o_badreq;
    logic [31:0] o_wdata, o_addr, o_bwd;
    logic [3:0]  o_be;
    logic        o_we, o_mis, o_err, o_unstable;

    // Model expectations
    logic        e_mem, e_we, e_mis, e_er;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_bwd, e_wd;
    int          e_lat;

    task automatic model_op(input logic [31:0] ins, result, rdata2, rdata, input int d);
        logic [5:0]  op;
        logic [31:0] lane;
        int          size, off;
        op  = ins[31:26];
        off = int'(result % 4);
        case (op)
            6'h20, 6'h24, 6'h28: size = 1;
            6'h21, 6'h25, 6'h29: size = 2;
            6'h23, 6'h2B:        size = 4;
            default:             size = 0;
        endcase
        e_mem  = (size != 0);
        e_we   = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        e_mis  = (size != 0) ? ((off % ((size == 0) ? 1 : size)) != 0) : 1'b0;
        e_addr = result - 32'(off);
        e_be   = (size == 4) ? 4'hF : (size == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'(1 << off);
        e_bwd  = (size == 4) ? rdata2 : (size == 2) ? {rdata2[15:0], rdata2[15:0]}
                                                    : {rdata2[7:0], rdata2[7:0], rdata2[7:0], rdata2[7:0]};
        e_er   = 1'b0;
        e_lat  = 0;
        if (!e_mem) e_wd = result;
        else if (e_mis) e_wd = 32'h0;
        else if (d >= TO) begin
            e_er = 1'b1; e_wd = 32'h0; e_lat = TO;
        end else begin
            e_lat = d + 1;
            lane  = rdata >> (8 * off);
            case (op)
                6'h20:   e_wd = {{24{lane[7]}}, lane[7:0]};
                6'h24:   e_wd = {24'h0, lane[7:0]};
                6'h21:   e_wd = {{16{lane[15]}}, lane[15:0]};
                6'h25:   e_wd = {16'h0, lane[15:0]};
                6'h23:   e_wd = rdata;
                default: e_wd = result;
            endcase
        end
    endtask

    // Issue one instruction and acknowledge after d request cycles (never if d >= TO).
    task automatic run_op(input logic [31:0] ins, result, rdata2, rdata, input int d);
        o_ov_it = -1; o_ov_cnt = 0; o_mis_cnt = 0; o_err_cnt = 0; o_req_cycles = 0;
        o_stall_cnt = 0; o_badreq = 0; o_unstable = 1'b0; o_wdata = 'x; o_mis = 1'bx; o_err = 1'bx;
        o_addr = 'x; o_be = 'x; o_we = 1'bx; o_bwd = 'x;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.ins = ins; bus.result = result; bus.rdata2 = rdata2; bus.dm_ack = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.ins = $urandom; bus.result = $urandom; bus.rdata2 = $urandom;
        for (int it = 0; it < 300; it++) begin
            bus.dm_ack   = 1'b0;
            bus.dm_rdata = $urandom;
            if (bus.stall) o_stall_cnt++;
            if (bus.dm_req) begin
                if (!bus.stall) o_badreq++;
                if (o_req_cycles == 0) {o_addr, o_be, o_we, o_bwd} = {bus.dm_addr, bus.dm_be, bus.dm_we, bus.dm_wdata};
                else if ({o_addr, o_be, o_we, o_bwd} !== {bus.dm_addr, bus.dm_be, bus.dm_we, bus.dm_wdata}) o_unstable = 1'b1;
                if (o_req_cycles == d) begin
                    bus.dm_ack = 1'b1; bus.dm_rdata = rdata;
                end
                o_req_cycles++;
            end
            if (bus.misalign) o_mis_cnt++;
            if (bus.err) o_err_cnt++;
            if (bus.out_valid) begin
                if (o_ov_cnt == 0) begin
                    o_ov_it = it; o_wdata = bus.wdata; o_mis = bus.misalign; o_err = bus.err;
                end
                o_ov_cnt++;
            end else if (o_ov_cnt > 0) break;
            @(negedge clk);
        end
        bus.dm_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.stall, bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_be, bus.dm_wdata,
             bus.out_valid, bus.wdata, bus.misalign, bus.err} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {bus.stall, bus.dm_req, bus.out_valid, bus.wdata});
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.ins = 32'h00000020; bus.result = 32'h55;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.wdata !== 32'h55) begin
            failures++; $display("FAIL first_after_reset got=%b/%h exp=1/00000055", bus.out_valid, bus.wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic [31:0] ins, res;
        run_op(32'h00000020, 32'h8, 32'h0, 32'h0, 0);
        checks++;
        if (o_ov_it !== 0 || o_wdata !== 32'h8 || o_ov_cnt !== 1) begin
            failures++; $display("FAIL add_pass got=it%0d/%h/n%0d exp=it0/00000008/n1", o_ov_it, o_wdata, o_ov_cnt);
        end
        checks++;
        if (o_stall_cnt !== 0) begin
            failures++; $display("FAIL add_stall got=%0d exp=0", o_stall_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            do ins = $urandom; while (ins[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B});
            res = $urandom;
            run_op(ins, res, $urandom, $urandom, 0);
            checks++;
            if (o_ov_it !== 0 || o_wdata !== res || o_mis !== 1'b0 || o_req_cycles !== 0) begin
                failures++; $display("FAIL pass_rand got=it%0d/%h/m%b exp=it0/%h/m0", o_ov_it, o_wdata, o_mis, res);
            end
        end
    endtask

    task automatic test_load();
        run_op(32'h80000000, 32'h103, 32'h0, 32'h80FFFFFF, 2);
        checks++;
        if (o_be !== 4'b1000 || o_addr !== 32'h100 || o_we !== 1'b0) begin
            failures++; $display("FAIL lb_bus got=be%b/%h/we%b exp=be1000/00000100/we0", o_be, o_addr, o_we);
        end
        checks++;
        if (o_wdata !== 32'hFFFFFF80 || o_ov_it !== 3 || o_req_cycles !== 3) begin
            failures++; $display("FAIL lb_data got=%h/it%0d/r%0d exp=ffffff80/it3/r3", o_wdata, o_ov_it, o_req_cycles);
        end
    endtask

    task automatic test_store();
        run_op(32'hA4000000, 32'h22, 32'h1234ABCD, 32'h0, 0);
        checks++;
        if (o_we !== 1'b1 || o_be !== 4'b1100 || o_bwd !== 32'hABCDABCD || o_addr !== 32'h20) begin
            failures++; $display("FAIL sh_bus got=we%b/be%b/%h exp=we1/be1100/abcdabcd", o_we, o_be, o_bwd);
        end
        checks++;
        if (o_wdata !== 32'h22 || o_ov_it !== 1 || o_mis !== 1'b0) begin
            failures++; $display("FAIL sh_done got=%h/it%0d exp=00000022/it1", o_wdata, o_ov_it);
        end
    endtask

    task automatic test_misalign();
        run_op(32'h8C000000, 32'h6, 32'h0, 32'h0, 0);
        checks++;
        if (o_req_cycles !== 0 || o_mis !== 1'b1 || o_wdata !== 32'h0 || o_ov_it !== 0 || o_mis_cnt !== 1) begin
            failures++; $display("FAIL lw_misalign got=r%0d/m%b/%h/it%0d exp=r0/m1/00000000/it0",
                                 o_req_cycles, o_mis, o_wdata, o_ov_it);
        end
    endtask

    task automatic test_timeout();
        run_op(32'h8C000000, 32'h40, 32'h0, 32'h0, 1000);
        checks++;
        if (o_req_cycles !== TO || o_err !== 1'b1 || o_err_cnt !== 1 || o_wdata !== 32'h0 || o_ov_it !== TO) begin
            failures++; $display("FAIL timeout got=r%0d/e%b/n%0d/%h exp=r%0d/e1/n1/0", o_req_cycles, o_err, o_err_cnt, o_wdata, TO);
        end
        run_op(32'h8C000000, 32'h44, 32'h0, 32'hDEADBEEF, TO - 1);
        checks++;
        if (o_req_cycles !== TO || o_err !== 1'b0 || o_err_cnt !== 0 || o_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL ack_at_timeout got=r%0d/e%b/%h exp=r%0d/e0/deadbeef", o_req_cycles, o_err, o_wdata, TO);
        end
    endtask

    task automatic test_ignore_ack();
        @(negedge clk);
        bus.in_valid = 1'b0; bus.dm_ack = 1'b1; bus.dm_rdata = 32'h12345678;
        @(negedge clk);
        bus.dm_ack = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0 || bus.dm_req !== 1'b0 || bus.err !== 1'b0) begin
            failures++; $display("FAIL idle_ack got=ov%b/st%b/rq%b exp=0/0/0", bus.out_valid, bus.stall, bus.dm_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        int acc, brk;
        logic accepted;
        acc = 0; brk = -1; accepted = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.ins = 32'h8C000000; bus.result = 32'h10;
        @(negedge clk);
        bus.ins = 32'h00000020; bus.result = 32'h77;
        for (int it = 0; it < 60; it++) begin
            bus.dm_ack = 1'b0;
            if (bus.out_valid) q.push_back(bus.wdata);
            if (bus.dm_req) begin
                if (acc == 1) begin
                    bus.dm_ack = 1'b1; bus.dm_rdata = 32'hCAFEF00D;
                end
                acc++;
            end
            if (accepted) bus.in_valid = 1'b0;
            if (!bus.stall && bus.in_valid) accepted = 1'b1;
            if (q.size() == 2) begin
                brk = it; break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.dm_ack = 1'b0;
        while (q.size() < 2) q.push_back('x);
        checks++;
        if (q[0] !== 32'hCAFEF00D || q[1] !== 32'h77 || brk !== 4) begin
            failures++; $display("FAIL back_to_back got=%h,%h@%0d exp=cafef00d,00000077@4", q[0], q[1], brk);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0) begin
            failures++; $display("FAIL b2b_no_repeat got=ov%b/st%b exp=0/0", bus.out_valid, bus.stall);
        end
    endtask

    task automatic test_reset_mid_access();
        int ov;
        logic [31:0] res;
        ov = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.ins = 32'h8C000000; bus.result = 32'h80;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dm_req !== 1'b1) begin
            failures++; $display("FAIL pre_reset_req got=%b exp=1", bus.dm_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dm_req !== 1'b0 || bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset got=rq%b/st%b/ov%b exp=0/0/0", bus.dm_req, bus.stall, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.dm_ack = 1'b1; bus.dm_rdata = 32'hFFFF0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.dm_ack = 1'b0;
            if (bus.out_valid || bus.dm_req) ov++;
        end
        checks++;
        if (ov !== 0) begin
            failures++; $display("FAIL post_reset_quiet got=%0d exp=0", ov);
        end
        res = $urandom;
        run_op(32'h00000020, res, 32'h0, 32'h0, 0);
        checks++;
        if (o_ov_it !== 0 || o_wdata !== res) begin
            failures++; $display("FAIL add_after_reset got=it%0d/%h exp=it0/%h", o_ov_it, o_wdata, res);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops[8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        logic [31:0] ins, res, rd2, rdat;
        logic        acc;
        int          d;
        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[31:26] = ops[$urandom_range(0, 7)];
            res  = $urandom;
            if ($urandom_range(0, 2) != 0) res[0] = 1'b0;
            rd2  = $urandom;
            rdat = $urandom;
            d    = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 4);
            model_op(ins, res, rd2, rdat, d);
            run_op(ins, res, rd2, rdat, d);
            acc = e_mem && !e_mis;
            checks++;
            if (o_ov_it !== e_lat || o_ov_cnt !== 1 || o_wdata !== e_wd) begin
                failures++; $display("FAIL rand_result ins=%h res=%h d=%0d got=it%0d/n%0d/%h exp=it%0d/n1/%h",
                                     ins, res, d, o_ov_it, o_ov_cnt, o_wdata, e_lat, e_wd);
            end
            checks++;
            if (o_mis !== e_mis || o_err !== e_er || o_mis_cnt !== int'(e_mis) || o_err_cnt !== int'(e_er)) begin
                failures++; $display("FAIL rand_flags ins=%h res=%h got=m%b/e%b/%0d/%0d exp=m%b/e%b",
                                     ins, res, o_mis, o_err, o_mis_cnt, o_err_cnt, e_mis, e_er);
            end
            checks++;
            if (o_req_cycles !== (acc ? e_lat : 0) || o_stall_cnt !== (acc ? e_lat + 1 : 0) || o_badreq !== 0) begin
                failures++; $display("FAIL rand_timing ins=%h got=r%0d/s%0d exp=r%0d/s%0d",
                                     ins, o_req_cycles, o_stall_cnt, acc ? e_lat : 0, acc ? e_lat + 1 : 0);
            end
            if (acc) begin
                checks++;
                if (o_addr !== e_addr || o_be !== e_be || o_we !== e_we || o_bwd !== e_bwd || o_unstable !== 1'b0) begin
                    failures++; $display("FAIL rand_bus ins=%h res=%h got=%h/%b/%b/%h/u%b exp=%h/%b/%b/%h/u0",
                                         ins, res, o_addr, o_be, o_we, o_bwd, o_unstable, e_addr, e_be, e_we, e_bwd);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.ins = 32'h0; bus.result = 32'h0; bus.rdata2 = 32'h0;
        bus.dm_rdata = 32'h0; bus.dm_ack = 1'b0;
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_ignore_ack();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
